// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: state encoding, width defaults and halt opcode.
package cpu_pkg;

    localparam int unsigned AddrWDefault  = 8;
    localparam int unsigned DataWDefault  = 32;
    localparam logic [3:0]  HaltOpDefault = 4'hF;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } fetch_state_e;

    // True when the opcode nibble of a fetched word requests a halt.
    function automatic logic is_halt_op(input logic [3:0] op, input logic [3:0] halt_op);
        return op == halt_op;
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment; wraps modulo 2^ADDR_W.
module program_counter
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = AddrWDefault,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_pc_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    // Next PC: redirect target beats sequential increment.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory and hands {instr, pc} to decode
// through a registered valid/ready slot. Handles redirect, back-pressure, start-up and halt.
// Optional build macro FETCH_PERF_EN adds saturating fetch/flush counters.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = AddrWDefault,
    parameter int unsigned       DATA_W   = DataWDefault,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(1),
    parameter logic [3:0]        HALT_OP  = HaltOpDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    fetch_state_e      state_q;
    logic              if_valid_q;
    logic [DATA_W-1:0] if_instr_q;
    logic [ADDR_W-1:0] if_pc_q;
    logic [ADDR_W-1:0] pc;
    logic              fetch;
    logic              halt_word;

    // Slot can take a new word when empty or being drained; redirect suppresses the fetch.
    assign fetch     = (state_q == StRun) && (!if_valid_q || if_ready) && !redirect_valid;
    assign halt_word = is_halt_op(imem_data[DATA_W-1 -: 4], HALT_OP);

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load_i    (redirect_valid),
        .load_pc_i (redirect_pc),
        .inc_i     (fetch),
        .pc_o      (pc)
    );

    // FSM and output slot: redirect flushes, fetch refills, a plain handshake empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!redirect_valid && start) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (fetch && halt_word) begin
                        state_q <= StHalted;
                    end
                end
                StHalted: begin
                    if (redirect_valid) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (redirect_valid) begin
                if_valid_q <= 1'b0;
            end else if (fetch) begin
                if_valid_q <= 1'b1;
                if_instr_q <= imem_data;
                if_pc_q    <= pc;
            end else if (if_valid_q && if_ready) begin
                if_valid_q <= 1'b0;
            end
        end
    end

    assign imem_addr = pc;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign halted    = (state_q == StHalted);

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counters: fetches, and redirects that throw away an unaccepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch && fetch_cnt_q != 16'hFFFF) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (redirect_valid && if_valid_q && !if_ready && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a behavioural model predicts delivered words,
// a monitor pops and compares them at each handshake.
module tb_instruction_fetch;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    logic [31:0] mem [256];
    assign imem_data = mem[imem_addr];

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 running, 2 halted; slot is a queue of at most one word.
    int    m_mode;
    int    m_pc;
    item_t m_slot[$];
    item_t expq[$];
    int    m_fetches;
    int    m_flushes;

    // Expected post-edge values, published by the driver for the monitor.
    logic        exp_valid;
    logic [7:0]  exp_addr;
    logic        exp_halted;
    item_t       exp_item;
    bit          exp_after_reset;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus and advance the model across the coming clock edge.
    task automatic step(input bit r, input bit s, input bit rv, input logic [7:0] rpc,
                        input bit rdy);
        item_t w;
        bit    can_fetch;
        @(negedge clk);
        reset          = r;
        start          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        if (r) begin
            m_mode = 0;
            m_pc   = 1;
            m_slot.delete();
            m_fetches = 0;
            m_flushes = 0;
        end else begin
            if (m_slot.size() > 0 && rdy) expq.push_back(m_slot[0]);
            if (rv) begin
                if (m_slot.size() > 0 && !rdy && m_flushes < 65535) m_flushes++;
                m_slot.delete();
                m_pc = rpc;
                if (m_mode == 2) m_mode = 1;
            end else begin
                can_fetch = (m_mode == 1) && (m_slot.size() == 0 || rdy);
                if (m_slot.size() > 0 && rdy) m_slot.delete();
                if (can_fetch) begin
                    w.pc    = 8'(m_pc);
                    w.instr = mem[m_pc];
                    m_slot.push_back(w);
                    if (m_fetches < 65535) m_fetches++;
                    m_pc = (m_pc + 1) % 256;
                    if (w.instr[31:28] == 4'hF) m_mode = 2;
                end else if (m_mode == 0 && s) begin
                    m_mode = 1;
                end
            end
        end
        exp_valid       = (m_slot.size() > 0);
        if (exp_valid) exp_item = m_slot[0];
        exp_addr        = 8'(m_pc);
        exp_halted      = (m_mode == 2);
        exp_after_reset = r;
    endtask

    // Monitor: pop on handshake just before the edge, then check visible state after it.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && if_valid === 1'b1 && if_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_transfer", {24'h0, if_pc, if_instr}, 64'h0);
                end else begin
                    e = expq.pop_front();
                    chk("xfer_pc", {56'h0, if_pc}, {56'h0, e.pc});
                    chk("xfer_instr", {32'h0, if_instr}, {32'h0, e.instr});
                end
            end
            @(posedge clk);
            #1;
            chk("if_valid", {63'h0, if_valid}, {63'h0, exp_valid});
            chk("imem_addr", {56'h0, imem_addr}, {56'h0, exp_addr});
            chk("halted", {63'h0, halted}, {63'h0, exp_halted});
            if (exp_valid) begin
                chk("slot_pc", {56'h0, if_pc}, {56'h0, exp_item.pc});
                chk("slot_instr", {32'h0, if_instr}, {32'h0, exp_item.instr});
            end
            if (exp_after_reset) begin
                chk("reset_instr", {32'h0, if_instr}, 64'h0);
                chk("reset_pc", {56'h0, if_pc}, 64'h0);
            end
`ifdef FETCH_PERF_EN
            chk("fetch_cnt", {48'h0, fetch_cnt}, 64'(m_fetches));
            chk("flush_cnt", {48'h0, flush_cnt}, 64'(m_flushes));
`endif
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]   = 32'h0000_0000;
        mem[1]   = 32'h1000_0011;
        mem[2]   = 32'h2000_0022;
        mem[3]   = 32'h3000_0033;
        mem[4]   = 32'h4000_0044;
        mem[5]   = 32'hF000_0000;
        mem[6]   = 32'h6000_0066;
        mem[7]   = 32'h7000_0077;
        mem[8]   = 32'h8000_0088;
        mem[255] = 32'h0F00_00FF;

        // Directed scenarios: start-up, stall, redirect flush, halt, wrap, reset mid-stream.
        step(1, 0, 0, 8'h00, 1);
        step(0, 1, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'h06, 0);
        repeat (3) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'h05, 1);
        repeat (4) step(0, 0, 0, 8'h00, 1);
        step(0, 1, 0, 8'h00, 1);
        step(0, 0, 1, 8'h01, 1);
        repeat (3) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'hFF, 1);
        repeat (3) step(0, 1, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'h03, 1);
        step(0, 1, 0, 8'h00, 1);

        // Randomised traffic.
        for (int c = 0; c < 4000; c++) begin
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
        end
        repeat (3) step(0, 0, 0, 8'h00, 1);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(expq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
